// File: rtl/dac_tx_sched.sv
// dac_tx_sched
// Two-requester scheduler feeding a 1-bit DAC. A training-pattern source and a
// payload source each offer W-bit words over valid/ready. One word at a time is
// accepted, shifted out MSB-first on a registered serial bit, and back-to-back
// words are chained with no idle cycle between them. Ties between the two
// requesters alternate round-robin.
//
// Ports
//   clk        single clock, rising edge
//   rstn       asynchronous active-low reset
//   en         scheduler enable (a word in flight always completes)
//   trn_valid  training word offered      trn_data  training word
//   trn_ready  training word accepted this cycle (combinational)
//   dat_valid  payload word offered       dat_data  payload word
//   dat_ready  payload word accepted this cycle (combinational)
//   out_bit    registered serial bit to the DAC
//   busy       a word is being serialized
//   src        source of the current/last word (1 = training, 0 = payload)
//   gap_cnt    saturating count of idle gaps after a word
module dac_tx_sched #(
    parameter int   W        = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         trn_valid,
    input  logic [W-1:0] trn_data,
    output logic         trn_ready,
    input  logic         dat_valid,
    input  logic [W-1:0] dat_data,
    output logic         dat_ready,
    output logic         out_bit,
    output logic         busy,
    output logic         src,
    output logic [7:0]   gap_cnt
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_shreg;      // bits still to be sent, next one at MSB
    logic           r_out;
    logic           r_src;
    logic           r_last_trn;   // last grant went to training
    logic [7:0]     r_gap;

    logic           w_last_bit;
    logic           w_slot;
    logic           w_gnt_trn;
    logic           w_gnt_dat;
    logic           w_xfer;
    logic [W-1:0]   w_word;

    assign w_last_bit = (r_cnt == LAST);

    // Accept slot: idle, or the LSB cycle of the current word so the next
    // word's MSB follows without a gap.
    assign w_slot = en & ((r_state == S_IDLE) | ((r_state == S_SHIFT) & w_last_bit));

    // Round-robin on ties: training wins unless it was the last one granted.
    assign w_gnt_trn = trn_valid & (~dat_valid | ~r_last_trn);
    assign w_gnt_dat = dat_valid & ~w_gnt_trn;

    // Gated by rstn so ready is low for the whole time reset is held.
    assign trn_ready = rstn & w_slot & w_gnt_trn;
    assign dat_ready = rstn & w_slot & w_gnt_dat;

    // A ready is only ever raised for a valid requester.
    assign w_xfer = trn_ready | dat_ready;
    assign w_word = trn_ready ? trn_data : dat_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_bit && !w_xfer) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_out      <= IDLE_BIT;
            r_src      <= 1'b0;
            r_last_trn <= 1'b0;
            r_gap      <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_xfer) begin
                r_out      <= w_word[W-1];
                r_shreg    <= {w_word[W-2:0], 1'b0};
                r_cnt      <= '0;
                r_src      <= trn_ready;
                r_last_trn <= trn_ready;
            end else if (r_state == S_SHIFT) begin
                if (w_last_bit) begin
                    r_out <= IDLE_BIT;
                    r_cnt <= '0;
                end else begin
                    r_out   <= r_shreg[W-1];
                    r_shreg <= {r_shreg[W-2:0], 1'b0};
                    r_cnt   <= r_cnt + CW'(1);
                end
            end

            // A gap is only counted when the scheduler was enabled and still
            // found nothing to chain onto the finishing word.
            if ((r_state == S_SHIFT) && w_last_bit && en && !w_xfer && (r_gap != 8'hFF))
                r_gap <= r_gap + 8'd1;
        end
    end

    assign out_bit = r_out;
    assign busy    = (r_state == S_SHIFT);
    assign src     = r_src;
    assign gap_cnt = r_gap;

endmodule

// File: tb/tb_dac_tx_sched.sv
module tb_dac_tx_sched;

    localparam int   W  = 8;
    localparam logic IB = 1'b0;

    logic       clk = 1'b0;
    logic       rstn, en;
    logic       trn_valid, dat_valid;
    logic [7:0] trn_data, dat_data;
    logic       trn_ready, dat_ready;
    logic       out_bit, busy, src;
    logic [7:0] gap_cnt;

    dac_tx_sched #(.W(W), .IDLE_BIT(IB)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .trn_valid(trn_valid), .trn_data(trn_data), .trn_ready(trn_ready),
        .dat_valid(dat_valid), .dat_data(dat_data), .dat_ready(dat_ready),
        .out_bit(out_bit), .busy(busy), .src(src), .gap_cnt(gap_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard of per-cycle expected {out_bit, busy, src}.
    logic [2:0] exq[$];
    logic [2:0] q_e;

    typedef struct {
        logic       tv;
        logic [7:0] td;
        logic       dv;
        logic [7:0] dd;
        logic       e_tr;
        logic       e_dr;
        logic       e_src;
        logic [7:0] e_word;
        logic [7:0] e_gap;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w, input logic s);
        for (int i = 7; i >= 0; i--) exq.push_back({w[i], 1'b1, s});
    endtask

    task automatic push_idle(input logic s, input int n);
        for (int i = 0; i < n; i++) exq.push_back({IB, 1'b0, s});
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exq.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (exq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected cycles left, want 0", exq.size());
            exq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (exq.size() > 0) begin
            q_e = exq.pop_front();
            chk("sb out_bit", out_bit, q_e[2]);
            chk("sb busy",    busy,    q_e[1]);
            chk("sb src",     src,     q_e[0]);
        end
    end

    initial begin
        //        tv    td     dv    dd     tr    dr    src   word   gap
        vt[0] = '{1'b1, 8'h81, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 8'h81, 8'd1}; // first tie -> training
        vt[1] = '{1'b0, 8'hEE, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 8'd2};
        vt[2] = '{1'b1, 8'h3C, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 8'h3C, 8'd3};
        vt[3] = '{1'b1, 8'h12, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 8'h34, 8'd4}; // last trn -> payload
        vt[4] = '{1'b1, 8'h56, 1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 8'h56, 8'd5}; // last dat -> training
        vt[5] = '{1'b0, 8'h99, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 8'h00, 8'd5}; // nothing valid
        vt[6] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 8'd6};

        rstn = 1'b0; en = 1'b1;
        trn_valid = 1'b1; dat_valid = 1'b1;
        trn_data = 8'hFF; dat_data = 8'hFF;
        #12;
        chk("rst out_bit",   out_bit,   IB);
        chk("rst busy",      busy,      1'b0);
        chk("rst src",       src,       1'b0);
        chk("rst gap_cnt",   gap_cnt,   8'd0);
        chk("rst trn_ready", trn_ready, 1'b0);
        chk("rst dat_ready", dat_ready, 1'b0);
        trn_valid = 1'b0; dat_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;

        // Table: one word at a time from IDLE.
        for (int v = 0; v < 7; v++) begin
            wait_drain();
            @(negedge clk);
            trn_valid = vt[v].tv; trn_data = vt[v].td;
            dat_valid = vt[v].dv; dat_data = vt[v].dd;
            #1;
            chk("vec trn_ready", trn_ready, vt[v].e_tr);
            chk("vec dat_ready", dat_ready, vt[v].e_dr);
            @(posedge clk);
            #1;
            trn_valid = 1'b0; dat_valid = 1'b0;
            trn_data = ~trn_data; dat_data = ~dat_data;
            if (vt[v].e_tr || vt[v].e_dr) push_word(vt[v].e_word, vt[v].e_src);
            push_idle(vt[v].e_src, 1);
            wait_drain();
            chk("vec gap_cnt", gap_cnt, 32'(vt[v].e_gap));
        end

        // Both always valid: strict alternation, no idle cycle.
        wait_drain();
        @(negedge clk);
        trn_valid = 1'b1; trn_data = 8'hFF;
        dat_valid = 1'b1; dat_data = 8'h00;
        #1;
        chk("alt trn_ready", trn_ready, 1'b1);
        chk("alt dat_ready", dat_ready, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) push_word((k % 2 == 0) ? 8'hFF : 8'h00, (k % 2 == 0));
        push_idle(1'b0, 1);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            #1;
            if (k % 8 == 0) begin
                chk("alt slot trn_ready", trn_ready, (k == 16));
                chk("alt slot dat_ready", dat_ready, (k != 16));
            end
            @(posedge clk);
        end
        #1;
        trn_valid = 1'b0; dat_valid = 1'b0;
        wait_drain();
        chk("alt gap_cnt", gap_cnt, 8'd7);

        // Training only, held: ready exactly at counter=7, stream continuous.
        @(negedge clk);
        trn_valid = 1'b1; trn_data = 8'hB4;
        #1;
        chk("trn first ready", trn_ready, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) push_word(8'hB4, 1'b1);
        push_idle(1'b1, 1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            chk("trn held trn_ready", trn_ready, (k % 8 == 0));
            chk("trn held dat_ready", dat_ready, 1'b0);
            @(posedge clk);
        end
        #1;
        trn_valid = 1'b0;
        wait_drain();
        chk("trn gap_cnt", gap_cnt, 8'd8);

        // en dropped at bit 3: word completes, nothing accepted, stays idle.
        @(negedge clk);
        dat_valid = 1'b1; dat_data = 8'hC3;
        #1;
        chk("en drop first ready", dat_ready, 1'b1);
        @(posedge clk);
        #1;
        push_word(8'hC3, 1'b0);
        push_idle(1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("en drop trn_ready", trn_ready, 1'b0);
            chk("en drop dat_ready", dat_ready, 1'b0);
        end
        dat_valid = 1'b0; en = 1'b1;
        wait_drain();
        chk("en drop gap_cnt", gap_cnt, 8'd8);

        // Reset at bit 5: outputs clear without a clock, next word from MSB.
        @(negedge clk);
        trn_valid = 1'b1; trn_data = 8'hFF;
        #1;
        chk("rst mid trn_ready", trn_ready, 1'b1);
        @(posedge clk);
        #1;
        trn_valid = 1'b0;
        for (int i = 0; i < 6; i++) exq.push_back({1'b1, 1'b1, 1'b1});
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        dat_valid = 1'b1; dat_data = 8'h96;
        #1;
        chk("rst mid out_bit",   out_bit,   IB);
        chk("rst mid busy",      busy,      1'b0);
        chk("rst mid src",       src,       1'b0);
        chk("rst mid gap_cnt",   gap_cnt,   8'd0);
        chk("rst mid dat_ready", dat_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst hold busy",      busy,      1'b0);
        chk("rst hold dat_ready", dat_ready, 1'b0);
        rstn = 1'b1;
        #1;
        chk("rst rel dat_ready", dat_ready, 1'b1);
        @(posedge clk);
        #1;
        dat_valid = 1'b0;
        push_word(8'h96, 1'b0);
        push_idle(1'b0, 1);
        wait_drain();
        chk("rst rel gap_cnt", gap_cnt, 8'd1);

        // 300 isolated payload words: gap_cnt saturates.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dat_valid = 1'b1; dat_data = 8'(i);
            @(posedge clk);
            #1;
            dat_valid = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            if (i == 99) chk("sat gap_cnt mid", gap_cnt, 8'd101);
        end
        chk("sat gap_cnt", gap_cnt, 8'd255);
        chk("sat busy",    busy,    1'b0);
        chk("sat out_bit", out_bit, IB);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule
